// File: rtl/la_capture_pkg.sv
// Shared types and helpers for the logic-analyser capture engine.
package la_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        READOUT,
        DONE
    } cap_state_e;

    // Comparator operands are zero-extended to this width; TRIG_W must not exceed it.
    localparam int TRIG_W_MAX = 32;

    function automatic logic trig_match(
        input logic [TRIG_W_MAX-1:0] probe,
        input logic [TRIG_W_MAX-1:0] value,
        input logic [TRIG_W_MAX-1:0] mask
    );
        return ((probe ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/la_capture_ram.sv
// Capture buffer: one write port, one registered read port with read enable.
// The read register holds its value while rd_en is low.
module la_capture_ram #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_sys,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: trigger comparators, circular capture, in-order readout.
//  state     | meaning
//  IDLE      | waiting for first arm
//  PRE_FILL  | writing the pre-trigger history, trigger ignored
//  WAIT_TRIG | writing continuously, watching for hit or forceTrig
//  POST      | writing samples after the trigger sample
//  READOUT   | streaming DEPTH samples oldest-first over valid/ready
//  DONE      | capture complete, waiting for re-arm
module la_capture_core
    import la_capture_pkg::*;
#(
    parameter int DATA_W   = 20,
    parameter int TRIG_W   = 10,
    parameter int DEPTH    = 256,
    parameter int NUM_TRIG = 2,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       crystalCLK,
    input  logic                       resetN,
    input  logic [DATA_W-1:0]          dataIn,
    input  logic [TRIG_W-1:0]          trigIn,
    input  logic                       armIn,
    input  logic                       forceTrig,
    input  logic [NUM_TRIG-1:0]        trigEnable,
    input  logic [NUM_TRIG*TRIG_W-1:0] trigValue,
    input  logic [NUM_TRIG*TRIG_W-1:0] trigMask,
    input  logic                       trigModeOr,
    input  logic [ADDR_W-1:0]          preTrigDepth,
    output logic                       armed,
    output logic                       triggered,
    output logic                       captureDone,
    output logic                       rdValid,
    output logic [DATA_W-1:0]          rdData,
    output logic                       rdLast,
    input  logic                       rdReady
);

    localparam int CNT_W = ADDR_W + 1;

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              triggered_q, triggered_d;
    logic              ram_vld_q, ram_vld_d;
    logic              ram_last_q, ram_last_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [NUM_TRIG-1:0] unit_match;
    logic                hit;
    logic [CNT_W-1:0]    post_left;
    logic                wr_en;
    logic                rd_en;
    logic                rd_hs;
    logic                load_out;
    logic [DATA_W-1:0]   ram_rd_data;

    always_comb begin
        unit_match = '0;
        for (int k = 0; k < NUM_TRIG; k++) begin
            unit_match[k] = trig_match(TRIG_W_MAX'(trigIn),
                                       TRIG_W_MAX'(trigValue[k*TRIG_W +: TRIG_W]),
                                       TRIG_W_MAX'(trigMask[k*TRIG_W +: TRIG_W]));
        end
    end

    // With no unit enabled the AND reduction would be vacuously true, so gate it off.
    assign hit = (|trigEnable) &&
                 (trigModeOr ? |(unit_match & trigEnable) : &(unit_match | ~trigEnable));

    // Samples still to write after the trigger sample.
    assign post_left = CNT_W'(DEPTH) - {1'b0, pre_q} - CNT_W'(1);

    // Readout pipeline: RAM read register feeds the output skid register.
    assign rd_hs    = out_vld_q & rdReady;
    assign load_out = ram_vld_q & (~out_vld_q | rd_hs);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_addr_d = trig_addr_q;
        pre_d       = pre_q;
        cnt_d       = cnt_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        ram_vld_d   = load_out ? 1'b0 : ram_vld_q;
        ram_last_d  = ram_last_q;

        if (armIn && state_q != READOUT) begin
            pre_d       = preTrigDepth;
            cnt_d       = '0;
            triggered_d = 1'b0;
            state_d     = (preTrigDepth == '0) ? WAIT_TRIG : PRE_FILL;
        end else begin
            case (state_q)
                PRE_FILL: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_d == {1'b0, pre_q}) begin
                        state_d = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (hit || forceTrig) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        if (post_left == '0) begin
                            state_d  = READOUT;
                            rd_ptr_d = wr_ptr_q - pre_q;
                            cnt_d    = CNT_W'(DEPTH);
                        end else begin
                            state_d = POST;
                            cnt_d   = post_left;
                        end
                    end
                end
                POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = READOUT;
                        rd_ptr_d = trig_addr_q - pre_q;
                        cnt_d    = CNT_W'(DEPTH);
                    end
                end
                READOUT: begin
                    // cnt_q counts reads still to issue; one read in flight per free slot.
                    if (cnt_q != '0 && (!ram_vld_q || load_out)) begin
                        rd_en      = 1'b1;
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        cnt_d      = cnt_q - CNT_W'(1);
                        ram_vld_d  = 1'b1;
                        ram_last_d = (cnt_q == CNT_W'(1));
                    end
                    if (rd_hs && out_last_q) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        if (load_out) begin
            out_vld_d  = 1'b1;
            out_last_d = ram_last_q;
            out_data_d = ram_rd_data;
        end else if (rd_hs) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge crystalCLK or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            pre_q       <= '0;
            cnt_q       <= '0;
            triggered_q <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_addr_q <= trig_addr_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            triggered_q <= triggered_d;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    la_capture_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_sys(crystalCLK),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q),
        .wr_data(dataIn),
        .rd_en  (rd_en),
        .rd_addr(rd_ptr_q),
        .rd_data(ram_rd_data)
    );

    assign armed       = (state_q == PRE_FILL) || (state_q == WAIT_TRIG);
    assign triggered   = triggered_q;
    assign captureDone = (state_q == READOUT) || (state_q == DONE);
    assign rdValid     = out_vld_q;
    assign rdData      = out_data_q;
    assign rdLast      = out_vld_q & out_last_q;

endmodule
